// File: rtl/clock_display_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clock_display_pkg
// Purpose : Shared widths and active-low segment constants for the
//           clock_display_scan multiplexed seven-segment driver.
//           Segment patterns are ordered {a,b,c,d,e,f,g}; a 0 lights
//           the segment.
// Rev     : 1.0  initial release
// ============================================================================
package clock_display_pkg;

  localparam int BCD_W     = 4;   // one BCD digit
  localparam int SEG_W     = 8;   // {a..g, dp}
  localparam int SEG7_W    = 7;   // a..g only
  localparam int POS_COUNT = 4;   // display positions
  localparam int IDX_W     = 2;   // log2(POS_COUNT)

  // Position that carries the lit decimal point (HH.MM / MM.SS separator).
  localparam logic [IDX_W-1:0] DP_POS = 2'd2;
  // Leftmost position, candidate for leading-zero blanking.
  localparam logic [IDX_W-1:0] MS_POS = 2'd3;

  // Active-low a..g patterns.
  localparam logic [SEG7_W-1:0] SEG_0    = 7'b0000001;
  localparam logic [SEG7_W-1:0] SEG_1    = 7'b1001111;
  localparam logic [SEG7_W-1:0] SEG_2    = 7'b0010010;
  localparam logic [SEG7_W-1:0] SEG_3    = 7'b0000110;
  localparam logic [SEG7_W-1:0] SEG_4    = 7'b1001100;
  localparam logic [SEG7_W-1:0] SEG_5    = 7'b0100100;
  localparam logic [SEG7_W-1:0] SEG_6    = 7'b0100000;
  localparam logic [SEG7_W-1:0] SEG_7    = 7'b0001111;
  localparam logic [SEG7_W-1:0] SEG_8    = 7'b0000000;
  localparam logic [SEG7_W-1:0] SEG_9    = 7'b0000100;
  localparam logic [SEG7_W-1:0] SEG_DASH = 7'b1111110;
  localparam logic [SEG7_W-1:0] SEG_OFF  = 7'b1111111;

  // Full 8-bit blank drive (segments and dp all dark).
  localparam logic [SEG_W-1:0] SEGS_BLANK = 8'hFF;

  // All anodes disabled.
  localparam logic [POS_COUNT-1:0] ANODE_OFF = 4'b1111;

  typedef enum logic {
    PAGE_MMSS = 1'b0,
    PAGE_HHMM = 1'b1
  } page_e;

  // Active-low one-hot anode pattern for a display position.
  function automatic logic [POS_COUNT-1:0] anode_sel(input logic [IDX_W-1:0] pos);
    anode_sel = ~(4'b0001 << pos);
  endfunction

endpackage : clock_display_pkg
`default_nettype wire

// File: rtl/bcd_to_ssd.sv
`default_nettype none
// ============================================================================
// Module  : bcd_to_ssd
// Purpose : Combinational BCD to seven-segment decoder, active-low a..g.
//           Codes 10..15 are not valid BCD and show a dash (g only).
// Ports   : bcd [3:0] in  - digit value
//           seg [6:0] out - {a,b,c,d,e,f,g}, 0 = segment lit
// Rev     : 1.0  initial release
// ============================================================================
module bcd_to_ssd
  import clock_display_pkg::*;
(
  input  logic [BCD_W-1:0]  bcd,
  output logic [SEG7_W-1:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule : bcd_to_ssd
`default_nettype wire

// File: rtl/clock_display_scan.sv
`default_nettype none
// ============================================================================
// Module  : clock_display_scan
// Purpose : 4-digit multiplexed common-anode seven-segment driver for a BCD
//           time-of-day counter. Shows MM:SS (page 0) or HH:MM (page 1).
//           The displayed digits are snapshotted once per scan frame so one
//           frame never mixes two counter values.
// Ports   : clk            in  - system clock, rising edge
//           rst_n          in  - asynchronous active-low reset
//           sec0..sec5 [3:0] in - BCD s units, s tens, m units, m tens,
//                                 h units, h tens
//           page           in  - 0 = MM:SS, 1 = HH:MM
//           ssd_ctl [3:0]  out - anode enables, active low, bit 0 rightmost
//           segs [7:0]     out - {a,b,c,d,e,f,g,dp}, active low
// Params  : SCAN_CYCLES    - cycles each position stays lit (2..65535)
// Config  : LEADING_ZERO_BLANK_EN - when defined, a zero hours-tens digit on
//           page 1 is blanked while its anode keeps strobing.
// Rev     : 1.0  initial release
// ============================================================================
module clock_display_scan
  import clock_display_pkg::*;
#(
  parameter int SCAN_CYCLES = 25000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BCD_W-1:0]     sec0,
  input  logic [BCD_W-1:0]     sec1,
  input  logic [BCD_W-1:0]     sec2,
  input  logic [BCD_W-1:0]     sec3,
  input  logic [BCD_W-1:0]     sec4,
  input  logic [BCD_W-1:0]     sec5,
  input  logic                 page,
  output logic [POS_COUNT-1:0] ssd_ctl,
  output logic [SEG_W-1:0]     segs
);

  localparam int          PRE_W   = 16;
  localparam logic [PRE_W-1:0] TICK_AT = PRE_W'(SCAN_CYCLES - 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PRE_W-1:0]                pre_cnt;
  logic [IDX_W-1:0]                idx;
  logic [POS_COUNT-1:0][BCD_W-1:0] shadow;
  page_e                           shadow_page;

  logic                            scan_tick;
  logic                            frame_end;
  logic [POS_COUNT-1:0][BCD_W-1:0] live_digits;

  logic [BCD_W-1:0]                cur_digit;
  logic [SEG7_W-1:0]               cur_seg7;
  logic                            cur_dp;
  logic                            cur_blank;
  logic [SEG_W-1:0]                segs_next;
  logic [POS_COUNT-1:0]            ctl_next;

  assign scan_tick = (pre_cnt == TICK_AT);
  // Last tick of position 3: snapshot and idx wrap share this edge, so the
  // first position of the new frame already decodes the fresh shadow.
  assign frame_end = scan_tick && (idx == MS_POS);

  // --------------------------------------------------------------------------
  // Prescaler
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (scan_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Position index, wraps naturally 3 -> 0
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (scan_tick) begin
      idx <= idx + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Frame snapshot
  // --------------------------------------------------------------------------
  always_comb begin
    live_digits = {sec3, sec2, sec1, sec0};
    if (page_e'(page) == PAGE_HHMM) begin
      live_digits = {sec5, sec4, sec3, sec2};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      shadow_page <= PAGE_MMSS;
    end else if (frame_end) begin
      shadow      <= live_digits;
      shadow_page <= page_e'(page);
    end
  end

  // --------------------------------------------------------------------------
  // Decode of the currently scanned position
  // --------------------------------------------------------------------------
  assign cur_digit = shadow[idx];

  bcd_to_ssd u_bcd_to_ssd (
    .bcd (cur_digit),
    .seg (cur_seg7)
  );

  assign cur_dp = (idx == DP_POS) ? 1'b0 : 1'b1;

  // A zero hours-tens digit is blanked only on the HH:MM page.
  assign cur_blank = LZB_EN
                     && (shadow_page == PAGE_HHMM)
                     && (idx == MS_POS)
                     && (shadow[MS_POS] == '0);

  always_comb begin
    segs_next = {cur_seg7, cur_dp};
    if (cur_blank) begin
      segs_next = SEGS_BLANK;
    end
  end

  assign ctl_next = anode_sel(idx);

  // --------------------------------------------------------------------------
  // Output registers: glitch-free pad drive, one cycle behind idx/shadow
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssd_ctl <= ANODE_OFF;
      segs    <= SEGS_BLANK;
    end else begin
      ssd_ctl <= ctl_next;
      segs    <= segs_next;
    end
  end

endmodule : clock_display_scan
`default_nettype wire

// File: tb/tb_clock_display_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_clock_display_scan
// Purpose : Self-checking bench for clock_display_scan with SCAN_CYCLES=4.
//           Stimulus pushes the expected {anode, segment} value of every
//           displayed position into a queue; a monitor pops an entry each
//           time the anode pattern changes and also checks dwell length and
//           segment stability within a position.
// Rev     : 1.0  initial release
// ============================================================================
module tb_clock_display_scan;

  localparam int SCAN = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sec0, sec1, sec2, sec3, sec4, sec5;
  logic       page;
  logic [3:0] ssd_ctl;
  logic [7:0] segs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] ctl;
    logic [7:0] segs;
    int         tag;   // frame*10 + position
  } exp_t;

  exp_t exp_q[$];

  clock_display_scan #(.SCAN_CYCLES(SCAN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sec0    (sec0),
    .sec1    (sec1),
    .sec2    (sec2),
    .sec3    (sec3),
    .sec4    (sec4),
    .sec5    (sec5),
    .page    (page),
    .ssd_ctl (ssd_ctl),
    .segs    (segs)
  );

  always #5 clk = ~clk;

  // Hand-decoded pattern values {a..g,dp}
  localparam logic [7:0] S0     = 8'h03;  // "0"
  localparam logic [7:0] S0DP   = 8'h02;  // "0."
  localparam logic [7:0] S1     = 8'h9F;  // "1"
  localparam logic [7:0] S2     = 8'h25;  // "2"
  localparam logic [7:0] S3DP   = 8'h0C;  // "3."
  localparam logic [7:0] S4     = 8'h99;  // "4"
  localparam logic [7:0] S5     = 8'h49;  // "5"
  localparam logic [7:0] S8     = 8'h01;  // "8"
  localparam logic [7:0] S9     = 8'h09;  // "9"
  localparam logic [7:0] S9DP   = 8'h08;  // "9."
  localparam logic [7:0] SDASH  = 8'hFD;  // "-"
  localparam logic [7:0] SBLANK = 8'hFF;

  task automatic push(input logic [3:0] c, input logic [7:0] s, input int tag);
    exp_t e;
    e.ctl = c; e.segs = s; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Push one frame, rightmost position first.
  task automatic push_frame(input int f, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3);
    push(4'b1110, p0, f*10 + 0);
    push(4'b1101, p1, f*10 + 1);
    push(4'b1011, p2, f*10 + 2);
    push(4'b0111, p3, f*10 + 3);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  logic [3:0] prev_ctl  = 4'b1111;
  logic [7:0] prev_segs = 8'hFF;
  int         run       = 0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_ctl  = 4'b1111;
      prev_segs = 8'hFF;
      run       = 0;
    end else if (ssd_ctl !== prev_ctl) begin
      if (prev_ctl !== 4'b1111) begin
        checks++;
        if (run != SCAN) begin
          errors++;
          $display("FAIL dwell ctl=%b: got %0d cycles expected %0d", prev_ctl, run, SCAN);
        end
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected position ctl=%b segs=%h: got event expected none", ssd_ctl, segs);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ssd_ctl !== e.ctl || segs !== e.segs) begin
          errors++;
          $display("FAIL pos f%0d.p%0d: got ctl=%b segs=%h expected ctl=%b segs=%h",
                   e.tag / 10, e.tag % 10, ssd_ctl, segs, e.ctl, e.segs);
        end
      end
      prev_ctl  = ssd_ctl;
      prev_segs = segs;
      run       = 1;
    end else begin
      run++;
      if (segs !== prev_segs) begin
        checks++;
        errors++;
        $display("FAIL segs_stable ctl=%b: got %h expected %h", ssd_ctl, segs, prev_segs);
        prev_segs = segs;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus (edge_no counts rising edges since reset release)
  // --------------------------------------------------------------------------
  int edge_no = 0;

  task automatic goto_edge(input int k);
    while (edge_no < k) begin
      @(posedge clk);
      edge_no++;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    page  = 1'b0;
    // 23:59:58
    sec5 = 4'd2; sec4 = 4'd3; sec3 = 4'd5; sec2 = 4'd9; sec1 = 4'd5; sec0 = 4'd8;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctl",  {28'd0, ssd_ctl}, 32'hF);
    check("reset_segs", {24'd0, segs},    32'hFF);

    // Frame 0 shows the cleared shadow; frame 1 the 23:59:58 snapshot, MM:SS.
    push_frame(0, S0, S0, S0DP, S0);
    push_frame(1, S8, S5, S9DP, S5);

    rst_n = 1'b1;   // released at a falling edge; next rising edge is edge 1

    // Mid frame 1: switch to HH:MM; visible from frame 2 only.
    goto_edge(20);
    page = 1'b1;
    push_frame(2, S9, S5, S3DP, S2);

    // During frame 2: back to MM:SS for frame 3.
    goto_edge(40);
    page = 1'b0;
    push_frame(3, S8, S5, S9DP, S5);

    // Frame 3, idx=1: seconds units 8 -> 9, seen only from frame 4.
    goto_edge(53);
    sec0 = 4'd9;
    push_frame(4, S9, S5, S9DP, S5);

    // Illegal BCD in seconds tens, frame 5.
    goto_edge(70);
    sec1 = 4'hC;
    push_frame(5, S9, SDASH, S9DP, S5);

    // 09:41 on HH:MM, frame 6; leading zero handling at position 3.
    goto_edge(85);
    sec5 = 4'd0; sec4 = 4'd9; sec3 = 4'd4; sec2 = 4'd1;
    page = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    push_frame(6, S1, S4, S9DP, SBLANK);
`else
    push_frame(6, S1, S4, S9DP, S0);
`endif
    push(4'b1110, S1, 70);

    goto_edge(117);
    check("queue_drained", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of a clock phase.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ctl",  {28'd0, ssd_ctl}, 32'hF);
    check("async_reset_segs", {24'd0, segs},    32'hFF);
    repeat (2) @(posedge clk);
    #1;
    check("held_reset_ctl", {28'd0, ssd_ctl}, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_clock_display_scan
`default_nettype wire

// File: doc/clock_display_scan.md
# clock_display_scan

Multiplexed 4-digit seven-segment driver that sits directly downstream of the BCD time-of-day counter. It takes the six BCD digits (seconds, minutes, hours; two digits each) and shows either MM:SS or HH:MM on a 4-digit common-anode display. It time-multiplexes the anodes and snapshots the digits once per scan frame so a frame never mixes two counter values.

## Interface
- `SCAN_CYCLES`, default 25000: clock cycles each digit stays lit; legal range 2..65535.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `sec0` in 4: BCD seconds units.
- `sec1` in 4: BCD seconds tens.
- `sec2` in 4: BCD minutes units.
- `sec3` in 4: BCD minutes tens.
- `sec4` in 4: BCD hours units.
- `sec5` in 4: BCD hours tens.
- `page` in 1: display page; 0 = MM:SS, 1 = HH:MM.
- `ssd_ctl` out 4: anode enables, active low; bit i = display position i (0 = rightmost).
- `segs` out 8: segment drive, active low, ordered {a,b,c,d,e,f,g,dp}.

## Operation
- **Prescaler:** `pre_cnt` counts 0..SCAN_CYCLES-1 and wraps to 0. `scan_tick` = (`pre_cnt` == SCAN_CYCLES-1).
- **Position index:** `idx` (2 bits) increments on `scan_tick` and wraps 3→0.
- **Frame snapshot:** on `scan_tick` with `idx`==3, `shadow[3:0]` and `shadow_page` are loaded from the live inputs.
  - page 0 loads {sec3,sec2,sec1,sec0}.
  - page 1 loads {sec5,sec4,sec3,sec2}.
  - `shadow[3]` maps to position 3.
  - A change on `page` mid-frame takes effect only at the next snapshot.
- **Decode:** BCD values 0–9 give standard patterns (0 = 7'b0000001 for a..g). Values 10–15 give a dash (g only: 7'b1111110).
- **Decimal point:** lit (dp=0) only at position 2, acting as the separator. Off at all other positions.
- **Anodes:** exactly one bit of `ssd_ctl` is low at any time after reset release: `ssd_ctl` = ~(1<<`idx`).
- **Simultaneous events:** a snapshot and the idx wrap 3→0 happen on the same edge. Position 0 of the new frame already shows the new shadow value.

## Timing
- **Reset values:**
  - `pre_cnt`=0, `idx`=0, `shadow`=0, `shadow_page`=0.
  - `ssd_ctl`=4'b1111 (all off), `segs`=8'hFF.
- **Output latency:** `ssd_ctl` and `segs` are registered, 1 cycle after `idx`/`shadow`. The first rising edge after reset release drives position 0 with the decoded value "0": `ssd_ctl`=4'b1110, `segs`=8'b00000011.
- **Dwell:** each position stays lit for exactly SCAN_CYCLES cycles. Frame period = 4×SCAN_CYCLES.
- **Snapshot rate:** input digits are sampled once per frame. Input changes between snapshots are invisible. Worst-case display lag is 4×SCAN_CYCLES+1 cycles.
- **Reset mid-frame:** the asynchronous reset returns everything to reset values immediately, with all outputs blank.

## Configuration
- `LEADING_ZERO_BLANK_EN`
  - Defined: when `shadow_page`=1 and `shadow[3]`==0, position 3 is blank (`segs`=8'hFF) while its anode still strobes. Example: 09:41 displays " 9.41".
  - Not defined: every position always shows its decoded digit.

## Structure
- **Shared package `clock_display_pkg`:**
  - `BCD_W`=4.
  - `SEG_W`=8.
  - Segment constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF` (active-low, a..g).
  - `ANODE_OFF`=4'b1111.
- **One sub-module, `bcd_to_ssd`:** combinational 4-bit BCD → 7-bit a..g, with dash for 10–15. Instantiated once, on the shadow digit selected by `idx`.
- **Top level:** holds the prescaler, `idx`, shadow registers, blanking, dp insertion and the output registers.

## Test plan
Run every test with SCAN_CYCLES=4.

1. **Reset:** hold `rst_n`=0 → `ssd_ctl`=4'b1111, `segs`=8'hFF. On release, the first edge gives `ssd_ctl`=4'b1110, `segs`=8'b00000011.
2. **Page 0:** inputs 23:59:58, `page`=0. After the first snapshot, one frame shows:
   - pos0 "8" = 8'b00000001
   - pos1 "5" = 8'b01001001
   - pos2 "9" with dp = 8'b00001000
   - pos3 "5" = 8'b01001001
   - Each position lasts 4 cycles, and the anodes rotate 1110→1101→1011→0111.
3. **Page 1 with mid-frame change:** same inputs, switch `page`=1 mid-frame. The current frame still shows 59:58. The next frame shows pos3 "2", pos2 "3." (dp lit), pos1 "5", pos0 "9".
4. **Snapshot isolation:** change `sec0` from 8 to 9 while `idx`=1. Position 0 keeps showing "8" until after the next `idx`==3 `scan_tick`, then shows "9" = 8'b00001001.
5. **Illegal BCD:** drive `sec1`=4'hC on page 0 → position 1 shows the dash, 8'b11111101.
6. **Leading-zero blank:** with `LEADING_ZERO_BLANK_EN` defined, hours 09 on page 1 → position 3 gives `segs`=8'hFF with `ssd_ctl`=4'b0111. With the macro undefined → position 3 shows "0" = 8'b00000011.
